capp_core: RTL and testbench
============================

# capp_core

Associative (content-addressable parallel processor) core of 100 words × 32 bits. It combines three parts:
- **Comparand/mask unit:** drives dual-rail mismatch lines.
- **Cell array:** stores the words and resolves per-word match, tagged write and wired-OR read.
- **Tag register:** holds the responder set, supports a "select first" priority resolver, and exports a some/none prefix chain.

It sits between the sequencing controller and the data path as the parallel search engine.

## Interface
- `WORDS`, 100, number of stored words (cells/tags).
- `WIDTH`, 32, bits per word.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  asynchronous, active-high reset.
- `comparand`  in  WIDTH  search key.
- `mask`  in  WIDTH  1 = bit participates in search.
- `perform_search`  in  1  enables mismatch-line drive.
- `set`  in  1  load all tags to 1.
- `select_first`  in  1  keep only lowest-index set tag.
- `write_lines`  in  2·WIDTH  dual-rail write: [2i+1]=write 1 to bit i, [2i]=write 0 to bit i.
- `mismatch_lines`  out  2·WIDTH  registered: [2i+1]=words with bit i=1 mismatch, [2i]=words with bit i=0 mismatch.
- `match_lines`  out  WORDS  combinational: word w has no active mismatch.
- `tag_wires`  out  WORDS  tag register.
- `read_lines`  out  WIDTH  bitwise OR of all tagged words.
- `some_none`  out  WORDS  prefix OR: `some_none[w] = |tag_wires[w:0]`. `some_none[WORDS-1]` = "some"; its inverse = "none".

## Operation
- **Compare, per clock:**
  - If `perform_search` and `mask[i]`: `mismatch[2i+1] = ~comparand[i]` and `mismatch[2i] = comparand[i]`.
  - Otherwise both rails of bit i are 0.
- **Match:** `match_lines[w] = 1` iff no bit i has an active rail that disagrees with `word[w][i]`. With all mismatch lines 0, every word matches.
- **Tags, per clock, priority order:**
  1. `set`: tags ← all 1.
  2. `select_first`: tags ← only the lowest-index set bit (all 0 if none).
  3. Else: tags ← tags & match_lines. Idle is therefore a hold, since all words match.
- **Write, per clock:** for each word with `tag_wires[w] = 1` and each bit i:
  - `[2i+1] = 1` only → bit set.
  - `[2i] = 1` only → bit cleared.
  - Both or neither → bit unchanged.
  - Writes use the tag value before the same-edge tag update.
- **Read:** combinational OR across tagged words. Returns 0 when no tag is set.
- **Reset:** cells, tags and mismatch register all cleared. Consequently `match_lines` = all 1, `read_lines` = 0, `some_none` = 0.

## Timing
- The mismatch register updates one edge after `comparand`/`mask`/`perform_search` are sampled.
- Tags reflect a search on the edge after that, i.e. 2 edges after `perform_search` is first sampled high.
- `set` and `select_first` take effect on the next edge.
- `set` asserted together with a search edge: `set` wins, and narrowing starts on the following edge.
- Repeated search edges with constant inputs are idempotent (AND with the same match).
- `select_first` with `perform_search` still high: `select_first` wins on that edge.
- Asynchronous `RST` mid-search aborts it immediately. The first post-reset edge behaves per the priority rules.

## Structure
- **Shared package:** `WORDS`, `WIDTH`, and the rail-index helpers (set rail = 2i+1, clear rail = 2i).
- **Sub-modules:** `capp_compare` (mismatch register), `capp_cells` (storage/match/write/read), `capp_tags` (tag register, priority resolver, prefix chain).
- The top level wires them together.

## Test plan
- **Reset, then search:** reset; `set` 1 cycle; `comparand` = 5, `mask` = 5, `perform_search` = 1 for 2 edges; then `select_first` = 1.
  - After the search: `tag_wires` = 0 (all cells are 0, bits 0 and 2 mismatch), `some_none` = 0.
  - After `select_first`: `tag_wires` stays 0.
- **Write all:** `set`; drive set rails for bits 0 and 2 (`write_lines` = 0x22) for one edge → `read_lines` = 5. Search 5/5 → all 100 tags = 1, `some_none` = all 1.
- **Select first:** after the full match above, `select_first` → only `tag_wires[0] = 1`; `some_none` = all 1.
  - Write clear rail bit 0 → word 0 = 4.
  - Search 5/5 after `set` → tags 1..99 = 1, tag 0 = 0, `some_none[0] = 0`.
- **Masked search:** `mask` = 0 with `perform_search` → `mismatch_lines` = 0, all words match, tags unchanged.
- **Dual-rail conflict:** both rails of bit 3 high on a tagged word → bit 3 unchanged.
- **Async reset mid-search:** assert `RST` between edges → `tag_wires`, `mismatch_lines` and `read_lines` go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/capp_pkg.sv
// Shared sizing and dual-rail index helpers for the associative processor core.
package capp_pkg;

   localparam int WORDS = 100;
   localparam int WIDTH = 32;

   // Rail 2i+1 carries "bit i = 1", rail 2i carries "bit i = 0".
   function automatic int set_rail(input int i);
      return 2 * i + 1;
   endfunction

   function automatic int clr_rail(input int i);
      return 2 * i;
   endfunction

endpackage

// File: rtl/capp_cells.sv
// Cell array: word storage, per-word match, tagged dual-rail write, wired-OR read.
// Match and read are combinational; writes land on the next edge; no backpressure.
module capp_cells
   import capp_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [2*WIDTH-1:0] i_mismatch_lines,
   input  logic [2*WIDTH-1:0] i_write_lines,
   input  logic [WORDS-1:0]   i_tags,
   output logic [WORDS-1:0]   o_match_lines,
   output logic [WIDTH-1:0]   o_read_lines
);

   logic [WIDTH-1:0] r_cells [WORDS];
   logic [WIDTH-1:0] w_mis_one;
   logic [WIDTH-1:0] w_mis_zero;
   logic [WIDTH-1:0] w_wr_set;
   logic [WIDTH-1:0] w_wr_clr;
   logic [WORDS-1:0] w_match;
   logic [WIDTH-1:0] w_read;

   // Both rails high on a bit is a conflict and leaves the bit alone.
   always_comb begin
      w_mis_one  = '0;
      w_mis_zero = '0;
      w_wr_set   = '0;
      w_wr_clr   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_mis_one[i]  = i_mismatch_lines[set_rail(i)];
         w_mis_zero[i] = i_mismatch_lines[clr_rail(i)];
         w_wr_set[i]   = i_write_lines[set_rail(i)] & ~i_write_lines[clr_rail(i)];
         w_wr_clr[i]   = i_write_lines[clr_rail(i)] & ~i_write_lines[set_rail(i)];
      end
   end

   always_comb begin
      w_match = '0;
      w_read  = '0;
      for (int w = 0; w < WORDS; w++) begin
         w_match[w] = ~|((w_mis_one & r_cells[w]) | (w_mis_zero & ~r_cells[w]));
         if (i_tags[w]) w_read = w_read | r_cells[w];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int w = 0; w < WORDS; w++) r_cells[w] <= '0;
      end else begin
         for (int w = 0; w < WORDS; w++) begin
            if (i_tags[w]) r_cells[w] <= (r_cells[w] | w_wr_set) & ~w_wr_clr;
         end
      end
   end

   assign o_match_lines = w_match;
   assign o_read_lines  = w_read;

endmodule

// File: rtl/capp_compare.sv
// Comparand/mask unit: registers the dual-rail mismatch lines.
// One edge from comparand/mask/perform_search to o_mismatch_lines; no backpressure.
module capp_compare
   import capp_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [WIDTH-1:0]   i_comparand,
   input  logic [WIDTH-1:0]   i_mask,
   input  logic               i_perform_search,
   output logic [2*WIDTH-1:0] o_mismatch_lines
);

   logic [2*WIDTH-1:0] w_next;
   logic [2*WIDTH-1:0] r_mismatch;

   always_comb begin
      w_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_perform_search && i_mask[i]) begin
            w_next[set_rail(i)] = ~i_comparand[i];
            w_next[clr_rail(i)] = i_comparand[i];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_mismatch <= '0;
      else       r_mismatch <= w_next;
   end

   assign o_mismatch_lines = r_mismatch;

endmodule

// File: rtl/capp_tags.sv
// Tag register with set / select-first / narrow-by-match priority and some/none prefix chain.
// Tags update on the next edge; prefix chain is combinational; no backpressure.
module capp_tags
   import capp_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_set,
   input  logic             i_select_first,
   input  logic [WORDS-1:0] i_match_lines,
   output logic [WORDS-1:0] o_tags,
   output logic [WORDS-1:0] o_some_none
);

   logic [WORDS-1:0] r_tags;
   logic [WORDS-1:0] w_first;
   logic [WORDS-1:0] w_some;
   logic             w_acc;

   // Two's-complement trick isolates the lowest set bit (zero stays zero).
   assign w_first = r_tags & (~r_tags + WORDS'(1));

   always_comb begin
      w_some = '0;
      w_acc  = 1'b0;
      for (int w = 0; w < WORDS; w++) begin
         w_acc     = w_acc | r_tags[w];
         w_some[w] = w_acc;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)               r_tags <= '0;
      else if (i_set)          r_tags <= '1;
      else if (i_select_first) r_tags <= w_first;
      else                     r_tags <= r_tags & i_match_lines;
   end

   assign o_tags      = r_tags;
   assign o_some_none = w_some;

endmodule

// File: rtl/capp_core.sv
// Associative parallel processor core: compare unit, cell array and tag register wired together.
// Search narrows tags two edges after perform_search; set/select_first act on the next edge.
module capp_core
   import capp_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [WIDTH-1:0]   i_comparand,
   input  logic [WIDTH-1:0]   i_mask,
   input  logic               i_perform_search,
   input  logic               i_set,
   input  logic               i_select_first,
   input  logic [2*WIDTH-1:0] i_write_lines,
   output logic [2*WIDTH-1:0] o_mismatch_lines,
   output logic [WORDS-1:0]   o_match_lines,
   output logic [WORDS-1:0]   o_tag_wires,
   output logic [WIDTH-1:0]   o_read_lines,
   output logic [WORDS-1:0]   o_some_none
);

   logic [2*WIDTH-1:0] w_mismatch;
   logic [WORDS-1:0]   w_match;
   logic [WORDS-1:0]   w_tags;

   capp_compare u_compare (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_comparand      (i_comparand),
      .i_mask           (i_mask),
      .i_perform_search (i_perform_search),
      .o_mismatch_lines (w_mismatch)
   );

   capp_cells u_cells (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_mismatch_lines (w_mismatch),
      .i_write_lines    (i_write_lines),
      .i_tags           (w_tags),
      .o_match_lines    (w_match),
      .o_read_lines     (o_read_lines)
   );

   capp_tags u_tags (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_set          (i_set),
      .i_select_first (i_select_first),
      .i_match_lines  (w_match),
      .o_tags         (w_tags),
      .o_some_none    (o_some_none)
   );

   assign o_mismatch_lines = w_mismatch;
   assign o_match_lines    = w_match;
   assign o_tag_wires      = w_tags;

endmodule

// File: tb/tb_capp_core.sv
// Directed bench for capp_core with hand-computed expectations.
module tb_capp_core;
   import capp_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [WIDTH-1:0]   comparand;
   logic [WIDTH-1:0]   mask;
   logic               perform_search;
   logic               set_t;
   logic               select_first;
   logic [2*WIDTH-1:0] write_lines;
   logic [2*WIDTH-1:0] mismatch_lines;
   logic [WORDS-1:0]   match_lines;
   logic [WORDS-1:0]   tag_wires;
   logic [WIDTH-1:0]   read_lines;
   logic [WORDS-1:0]   some_none;

   logic [WORDS-1:0] all1;
   logic [WORDS-1:0] only0;
   logic [WORDS-1:0] not0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   capp_core dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_comparand      (comparand),
      .i_mask           (mask),
      .i_perform_search (perform_search),
      .i_set            (set_t),
      .i_select_first   (select_first),
      .i_write_lines    (write_lines),
      .o_mismatch_lines (mismatch_lines),
      .o_match_lines    (match_lines),
      .o_tag_wires      (tag_wires),
      .o_read_lines     (read_lines),
      .o_some_none      (some_none)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      all1  = '1;
      only0 = '0;
      only0[0] = 1'b1;
      not0  = all1;
      not0[0] = 1'b0;

      rst = 1'b1;
      comparand = '0;
      mask = '0;
      perform_search = 1'b0;
      set_t = 1'b0;
      select_first = 1'b0;
      write_lines = '0;
      step();
      check("rst_tags", tag_wires, '0);
      check("rst_mism", mismatch_lines, '0);
      check("rst_match", match_lines, all1);
      check("rst_read", read_lines, '0);
      check("rst_some", some_none, '0);
      rst = 1'b0;

      // Reset, then search against empty cells
      set_t = 1'b1; step(); set_t = 1'b0;
      check("set_tags", tag_wires, all1);
      comparand = 32'd5; mask = 32'd5; perform_search = 1'b1;
      step();
      check("s1_mism", mismatch_lines, 64'h11);
      check("s1_match", match_lines, '0);
      step();
      perform_search = 1'b0;
      check("s1_tags", tag_wires, '0);
      check("s1_some", some_none, '0);
      step();
      select_first = 1'b1; step(); select_first = 1'b0;
      check("sf_empty", tag_wires, '0);

      // Write all words to 5, then search 5/5
      set_t = 1'b1; step(); set_t = 1'b0;
      write_lines = 64'h22; step(); write_lines = '0;
      check("wr_read", read_lines, 32'd5);
      perform_search = 1'b1;
      step();
      check("s2_match", match_lines, all1);
      step();
      perform_search = 1'b0;
      step();
      check("s2_tags", tag_wires, all1);
      check("s2_some", some_none, all1);

      // Select first, clear bit 0 of word 0, search again after set
      select_first = 1'b1; step(); select_first = 1'b0;
      check("sf_tags", tag_wires, only0);
      check("sf_some", some_none, all1);
      write_lines = 64'h1; step(); write_lines = '0;
      check("w0_read", read_lines, 32'd4);
      set_t = 1'b1; step(); set_t = 1'b0;
      perform_search = 1'b1;
      step(); step();
      perform_search = 1'b0;
      step();
      check("s3_tags", tag_wires, not0);
      check("s3_some", some_none, not0);
      check("s3_read", read_lines, 32'd5);

      // Masked search: nothing participates
      mask = '0; perform_search = 1'b1;
      step();
      check("mk_mism", mismatch_lines, '0);
      check("mk_match", match_lines, all1);
      step();
      perform_search = 1'b0;
      check("mk_tags", tag_wires, not0);

      // Dual-rail conflict on bit 3 alongside a plain set of bit 1
      write_lines = 64'hC8; step(); write_lines = '0;
      check("dr_read", read_lines, 32'd7);
      write_lines = 64'h03; step(); write_lines = '0;
      check("dr_bit0", read_lines, 32'd7);

      // Async reset between edges during a search
      comparand = 32'd7; mask = 32'd7; perform_search = 1'b1;
      step();
      check("ar_mism", mismatch_lines, 64'h15);
      #2 rst = 1'b1;
      #1;
      check("ar_tags", tag_wires, '0);
      check("ar_mism0", mismatch_lines, '0);
      check("ar_read", read_lines, '0);
      rst = 1'b0;
      perform_search = 1'b0;
      step();

      // Set together with a search edge: set wins, narrowing follows
      comparand = 32'd5; mask = 32'd5; perform_search = 1'b1; set_t = 1'b1;
      step();
      set_t = 1'b0;
      check("ss_tags", tag_wires, all1);
      check("ss_read", read_lines, '0);
      step();
      perform_search = 1'b0;
      check("ss_narrow", tag_wires, '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
